mmio_resp_arb: RTL and testbench

- Parametrised MMIO response arbiter and bus-watchdog between the L2 MMIO port and N peripheral modules.
- Replaces the fixed per-device if/else response chain in the top-level core unit; the device count is now a parameter.
- Selects the responding device by fixed priority and forwards its data and OK code to L2.
- Faults unanswered requests after a timeout, instead of only printing a miss, and logs the miss address.
- Detects multi-device response collisions and generates the periodic timer exception word for the CPU.

---
 rtl/mmio_resp_arb_pkg.sv | 30 +++
 rtl/mmio_resp_arb_if.sv | 29 ++
 rtl/mmio_prio_enc.sv | 34 +++
 rtl/mmio_resp_arb.sv | 159 +++++++++++++++
 tb/tb_mmio_resp_arb.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_resp_arb_pkg.sv
// Shared constants, state encoding and payload types for the MMIO response arbiter.
package mmio_resp_arb_pkg;

  localparam logic [1:0] UMEM_OK_READY = 2'b00;
  localparam logic [1:0] UMEM_OK_OK    = 2'b01;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'b10;
  localparam logic [1:0] UMEM_OK_FAULT = 2'b11;

  localparam logic [63:0] UV64_00 = 64'h0;
  localparam logic [31:0] UV32_00 = 32'h0;

  localparam logic [15:0] EXC_TIMER_DEF = 16'hC001;

  typedef enum logic [1:0] {
    WD_IDLE = 2'd0,
    WD_WAIT = 2'd1,
    WD_FLT  = 2'd2
  } wd_state_e;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  ok;
  } mmio_resp_t;

  // Index width for an n-entry one-hot vector; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_resp_arb_if.sv
// L2-side request/response bus plus per-device response channels and status outputs.
interface mmio_resp_arb_if #(
  parameter int unsigned NDEV  = 8,
  parameter int unsigned CNT_W = 16
);
  logic [31:0]        mmioAddr;
  logic [4:0]         mmioOpm;
  logic [64*NDEV-1:0] devOutData;
  logic [2*NDEV-1:0]  devOK;
  logic               timerTick;
  logic               stsClr;
  logic [63:0]        mmioInData;
  logic [1:0]         mmioOK;
  logic [63:0]        busExc;
  logic [31:0]        missAddr;
  logic [CNT_W-1:0]   missCount;
  logic               collFlag;
  logic [NDEV-1:0]    collMask;

  modport slave (
    input  mmioAddr, mmioOpm, devOutData, devOK, timerTick, stsClr,
    output mmioInData, mmioOK, busExc, missAddr, missCount, collFlag, collMask
  );

  modport master (
    output mmioAddr, mmioOpm, devOutData, devOK, timerTick, stsClr,
    input  mmioInData, mmioOK, busExc, missAddr, missCount, collFlag, collMask
  );
endinterface

// File: rtl/mmio_prio_enc.sv
// Fixed-priority encoder: index 0 wins; also flags more than one active request.
module mmio_prio_enc
  import mmio_resp_arb_pkg::*;
#(
  parameter  int unsigned NDEV  = 8,
  localparam int unsigned IDX_W = idx_w(NDEV)
) (
  input  logic [NDEV-1:0]  req,
  output logic [NDEV-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             multi
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NDEV; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(req & (req - NDEV'(1)));

endmodule

// File: rtl/mmio_resp_arb.sv
// MMIO response arbiter: priority response mux, request watchdog, collision capture, timer exception.
module mmio_resp_arb
  import mmio_resp_arb_pkg::*;
#(
  parameter int unsigned NDEV      = 8,
  parameter int unsigned TMO_CYC   = 256,
  parameter int unsigned CNT_W     = 16,
  parameter logic [15:0] EXC_TIMER = EXC_TIMER_DEF
) (
  input logic             clock,
  input logic             reset,
  mmio_resp_arb_if.slave  bus
);

  localparam int unsigned IDX_W = idx_w(NDEV);
  localparam int unsigned TMO_W = $clog2(TMO_CYC) + 1;

  logic [63:0]      dev_data [NDEV];
  logic [1:0]       dev_ok   [NDEV];
  logic [NDEV-1:0]  req_mask;
  logic [NDEV-1:0]  hit_grant;
  logic [IDX_W-1:0] hit_idx;
  logic             hit_valid;
  logic             hit_multi;
  mmio_resp_t       resp;

  wd_state_e        state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic [31:0]      miss_addr_q, miss_addr_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;
  logic [CNT_W-1:0] miss_base;
  logic             coll_flag_q, coll_flag_d;
  logic [NDEV-1:0]  coll_mask_q, coll_mask_d;
  logic             miss_evt;
  logic             req_act;

  for (genvar g = 0; g < NDEV; g++) begin : g_unpack
    assign dev_data[g] = bus.devOutData[64*g +: 64];
    assign dev_ok[g]   = bus.devOK[2*g +: 2];
    assign req_mask[g] = (bus.devOK[2*g +: 2] != UMEM_OK_READY);
  end

  mmio_prio_enc #(.NDEV(NDEV)) u_prio_enc (
    .req   (req_mask),
    .grant (hit_grant),
    .idx   (hit_idx),
    .valid (hit_valid),
    .multi (hit_multi)
  );

  // Device response beats a pending FAULT; data is forced to zero when nobody answers.
  always_comb begin
    resp = '{data: UV64_00, ok: UMEM_OK_READY};
    if (hit_valid) begin
      resp.data = dev_data[hit_idx];
      for (int unsigned i = 0; i < NDEV; i++) begin
        if (hit_grant[i]) resp.ok = dev_ok[i];
      end
    end else if (state_q == WD_FLT) begin
      resp.ok = UMEM_OK_FAULT;
    end
  end

  assign bus.mmioInData = resp.data;
  assign bus.mmioOK     = resp.ok;
  assign bus.busExc     = bus.timerTick ? {48'h0, EXC_TIMER} : UV64_00;
  assign bus.missAddr   = miss_addr_q;
  assign bus.missCount  = miss_count_q;
  assign bus.collFlag   = coll_flag_q;
  assign bus.collMask   = coll_mask_q;

  assign req_act = (bus.mmioOpm != 5'd0);

  // Watchdog next state and status updates.
  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    req_addr_d  = req_addr_q;
    miss_addr_d = miss_addr_q;
    miss_evt    = 1'b0;

    unique case (state_q)
      WD_IDLE: begin
        if (req_act && !hit_valid) begin
          req_addr_d = bus.mmioAddr;
          if (TMO_CYC == 1) begin
            state_d     = WD_FLT;
            tmo_cnt_d   = '0;
            miss_addr_d = bus.mmioAddr;
            miss_evt    = 1'b1;
          end else begin
            state_d   = WD_WAIT;
            tmo_cnt_d = TMO_W'(1);
          end
        end
      end
      WD_WAIT: begin
        if (hit_valid || !req_act) begin
          state_d   = WD_IDLE;
          tmo_cnt_d = '0;
        end else if (bus.mmioAddr != req_addr_q) begin
          tmo_cnt_d  = TMO_W'(1);
          req_addr_d = bus.mmioAddr;
        end else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
          state_d     = WD_FLT;
          tmo_cnt_d   = '0;
          miss_addr_d = req_addr_q;
          miss_evt    = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      WD_FLT: begin
        if (!req_act) state_d = WD_IDLE;
      end
      default: begin
        state_d   = WD_IDLE;
        tmo_cnt_d = '0;
      end
    endcase

    // A clear in the same cycle as a timeout still counts that timeout.
    miss_base    = bus.stsClr ? '0 : miss_count_q;
    miss_count_d = miss_base;
    if (miss_evt && (miss_base != {CNT_W{1'b1}})) miss_count_d = miss_base + CNT_W'(1);

    coll_flag_d = coll_flag_q;
    coll_mask_d = coll_mask_q;
    if (hit_multi && (!coll_flag_q || bus.stsClr)) begin
      coll_flag_d = 1'b1;
      coll_mask_d = req_mask;
    end else if (bus.stsClr) begin
      coll_flag_d = 1'b0;
      coll_mask_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= WD_IDLE;
      tmo_cnt_q    <= '0;
      req_addr_q   <= UV32_00;
      miss_addr_q  <= UV32_00;
      miss_count_q <= '0;
      coll_flag_q  <= 1'b0;
      coll_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      req_addr_q   <= req_addr_d;
      miss_addr_q  <= miss_addr_d;
      miss_count_q <= miss_count_d;
      coll_flag_q  <= coll_flag_d;
      coll_mask_q  <= coll_mask_d;
    end
  end

endmodule

// File: tb/tb_mmio_resp_arb.sv
// Bench for mmio_resp_arb: vector table, directed watchdog/collision sequences, random run vs. reference model.
module tb_mmio_resp_arb;

  localparam int NDEV  = 8;
  localparam int TMO   = 256;
  localparam int CNT_W = 4;          // narrow counter so saturation is reachable quickly
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mmio_resp_arb_if #(.NDEV(NDEV), .CNT_W(CNT_W)) bus ();

  mmio_resp_arb #(.NDEV(NDEV), .TMO_CYC(TMO), .CNT_W(CNT_W), .EXC_TIMER(16'hC001)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // stimulus for the current cycle
  logic [31:0] i_addr;
  logic [4:0]  i_opm;
  logic [1:0]  i_ok   [NDEV];
  logic [63:0] i_data [NDEV];
  logic        i_tick, i_clr, i_rst;

  // reference model: "age" = consecutive unanswered cycles on one address
  bit          m_valid = 0;
  bit          m_flt;
  int          m_age;
  logic [31:0] m_paddr, m_maddr;
  int          m_cnt;
  bit          m_cf;
  logic [7:0]  m_cm;

  typedef struct {
    logic [15:0] devok;
    logic        tick;
    logic [1:0]  exp_ok;
    logic [63:0] exp_data;
    logic [63:0] exp_exc;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] def_data(input int d);
    return 64'h1111_1111_1111_1111 * (d + 1);
  endfunction

  task automatic idle_inputs();
    i_opm = 5'd0; i_tick = 1'b0; i_clr = 1'b0; i_rst = 1'b0;
    for (int d = 0; d < NDEV; d++) begin
      i_ok[d] = 2'd0; i_data[d] = def_data(d);
    end
  endtask

  task automatic check_model();
    logic [1:0]  e_ok;
    logic [63:0] e_data, e_exc;
    bit hit;
    hit = 0; e_ok = m_flt ? 2'b11 : 2'b00; e_data = 64'h0;
    for (int d = 0; d < NDEV; d++)
      if (!hit && i_ok[d] != 2'd0) begin hit = 1; e_ok = i_ok[d]; e_data = i_data[d]; end
    e_exc = i_tick ? 64'h0000_0000_0000_C001 : 64'h0;
    n_vec++;
    if (bus.mmioOK !== e_ok || bus.mmioInData !== e_data || bus.busExc !== e_exc ||
        bus.missAddr !== m_maddr || bus.missCount !== CNT_W'(m_cnt) ||
        bus.collFlag !== m_cf || bus.collMask !== m_cm) begin
      n_bad++;
      $display("FAIL model cyc=%0d ok=%0d/%0d data=%h/%h exc=%h/%h maddr=%h/%h mcnt=%0d/%0d cf=%0d/%0d cm=%b/%b (got/exp)",
               cyc, bus.mmioOK, e_ok, bus.mmioInData, e_data, bus.busExc, e_exc, bus.missAddr, m_maddr,
               bus.missCount, m_cnt, bus.collFlag, m_cf, bus.collMask, m_cm);
    end
  endtask

  task automatic update_model();
    int n; bit miss; logic [7:0] mask;
    if (i_rst) begin
      m_valid = 1; m_flt = 0; m_age = 0; m_paddr = '0; m_maddr = '0; m_cnt = 0; m_cf = 0; m_cm = '0;
    end else if (m_valid) begin
      n = 0; mask = '0; miss = 0;
      for (int d = 0; d < NDEV; d++) if (i_ok[d] != 2'd0) begin n++; mask[d] = 1'b1; end
      if (m_flt) begin
        if (i_opm == 0) m_flt = 0;
      end else begin
        if (m_age == 0) begin
          if (i_opm != 0 && n == 0) begin m_age = 1; m_paddr = i_addr; end
        end else if (n != 0 || i_opm == 0) m_age = 0;
        else if (i_addr != m_paddr) begin m_age = 1; m_paddr = i_addr; end
        else m_age++;
        if (m_age == TMO) begin m_flt = 1; m_age = 0; miss = 1; m_maddr = m_paddr; end
      end
      if (i_clr) m_cnt = 0;
      if (miss && m_cnt < MAXC) m_cnt++;
      if (n >= 2 && (!m_cf || i_clr)) begin m_cf = 1; m_cm = mask; end
      else if (i_clr) begin m_cf = 0; m_cm = '0; end
    end
  endtask

  // apply inputs and let combinational outputs settle (sampled at negedge)
  task automatic drive();
    bus.mmioAddr = i_addr; bus.mmioOpm = i_opm;
    bus.timerTick = i_tick; bus.stsClr = i_clr; reset = i_rst;
    for (int d = 0; d < NDEV; d++) begin
      bus.devOK[2*d +: 2] = i_ok[d];
      bus.devOutData[64*d +: 64] = i_data[d];
    end
    @(negedge clock);
    if (m_valid) check_model();
  endtask

  task automatic advance();
    @(posedge clock);
    update_model();
    cyc++;
    #1;
  endtask

  task automatic step();
    drive(); advance();
  endtask

  task automatic do_reset();
    idle_inputs(); i_rst = 1'b1; step(); step(); i_rst = 1'b0;
  endtask

  // hold an unanswered request TMO cycles; FAULT is due on the next drive
  task automatic wait_fault(input logic [31:0] a, input bit clr_last, output int bad);
    bad = 0; i_opm = 5'd1; i_addr = a;
    for (int k = 0; k < TMO; k++) begin
      i_clr = clr_last && (k == TMO - 1);
      drive(); if (bus.mmioOK !== 2'b00) bad++; advance();
    end
    i_clr = 1'b0;
  endtask

  task automatic drop();
    i_opm = 5'd0; step(); step();
  endtask

  initial begin
    int bad;
    bit quiet;
    i_addr = 32'h0;
    tbl[0] = '{16'h0000, 1'b0, 2'd0, 64'h0,                    64'h0};
    tbl[1] = '{16'h0001, 1'b0, 2'd1, 64'h1111_1111_1111_1111, 64'h0};
    tbl[2] = '{16'hC000, 1'b0, 2'd3, 64'h8888_8888_8888_8888, 64'h0};
    tbl[3] = '{16'h1080, 1'b0, 2'd2, 64'h4444_4444_4444_4444, 64'h0};
    tbl[4] = '{16'h0410, 1'b0, 2'd1, 64'h3333_3333_3333_3333, 64'h0};
    tbl[5] = '{16'h0000, 1'b1, 2'd0, 64'h0,                    64'h0000_0000_0000_C001};
    tbl[6] = '{16'h0008, 1'b1, 2'd2, 64'h2222_2222_2222_2222, 64'h0000_0000_0000_C001};
    tbl[7] = '{16'h0007, 1'b0, 2'd3, 64'h1111_1111_1111_1111, 64'h0};

    do_reset();
    drive();
    chk("rst_ok", 64'(bus.mmioOK), 64'd0);
    chk("rst_miss_cnt", 64'(bus.missCount), 64'd0);
    chk("rst_miss_addr", 64'(bus.missAddr), 64'd0);
    chk("rst_coll", {55'd0, bus.collFlag, bus.collMask}, 64'd0);
    advance();

    for (int v = 0; v < 8; v++) begin
      for (int d = 0; d < NDEV; d++) i_ok[d] = tbl[v].devok[2*d +: 2];
      i_tick = tbl[v].tick;
      i_opm  = (tbl[v].devok != 16'h0) ? 5'd1 : 5'd0;
      drive();
      chk($sformatf("tbl%0d_ok", v), 64'(bus.mmioOK), 64'(tbl[v].exp_ok));
      chk($sformatf("tbl%0d_data", v), bus.mmioInData, tbl[v].exp_data);
      chk($sformatf("tbl%0d_exc", v), bus.busExc, tbl[v].exp_exc);
      advance();
    end

    // collision capture and clear
    do_reset();
    i_opm = 5'd1; i_ok[2] = 2'd1; i_ok[5] = 2'd1;
    i_data[2] = 64'hAAAA_0000_0000_0002; i_data[5] = 64'hBBBB_0000_0000_0005;
    drive();
    chk("coll_data", bus.mmioInData, 64'hAAAA_0000_0000_0002);
    chk("coll_ok", 64'(bus.mmioOK), 64'd1);
    advance();
    idle_inputs(); i_ok[1] = 2'd2; i_ok[3] = 2'd1;
    drive();
    chk("coll_flag", 64'(bus.collFlag), 64'd1);
    chk("coll_mask", 64'(bus.collMask), 64'h24);
    advance();
    idle_inputs(); drive();
    chk("coll_mask_kept", 64'(bus.collMask), 64'h24);
    advance();
    i_clr = 1'b1; step(); i_clr = 1'b0;
    drive(); chk("coll_clr", {55'd0, bus.collFlag, bus.collMask}, 64'd0); advance();
    i_ok[0] = 2'd1; i_ok[7] = 2'd3; step();
    idle_inputs(); i_clr = 1'b1; i_ok[1] = 2'd1; i_ok[3] = 2'd2; step();
    idle_inputs(); drive();
    chk("coll_clr_wins", {55'd0, bus.collFlag, bus.collMask}, {55'd0, 1'b1, 8'h0A});
    advance();

    // plain timeout
    do_reset();
    wait_fault(32'hF00B_0000, 1'b0, bad);
    chk("tmo_ready_window", 64'(bad), 64'd0);
    drive();
    chk("tmo_fault", 64'(bus.mmioOK), 64'd3);
    chk("tmo_miss_addr", 64'(bus.missAddr), 64'hF00B_0000);
    chk("tmo_miss_cnt", 64'(bus.missCount), 64'd1);
    advance();
    i_opm = 5'd0; step();
    drive(); chk("tmo_released", 64'(bus.mmioOK), 64'd0); advance();

    // address change restarts the watchdog
    bad = 0; i_opm = 5'd1;
    for (int k = 0; k < 456; k++) begin
      i_addr = (k < 200) ? 32'hF00B_0000 : 32'hF00C_0040;
      drive(); if (bus.mmioOK !== 2'b00) bad++; advance();
    end
    chk("restart_ready_window", 64'(bad), 64'd0);
    drive();
    chk("restart_fault", 64'(bus.mmioOK), 64'd3);
    chk("restart_miss_addr", 64'(bus.missAddr), 64'hF00C_0040);
    chk("restart_miss_cnt", 64'(bus.missCount), 64'd2);
    advance();
    drop();

    // long HOLD never faults
    bad = 0; i_opm = 5'd1; i_addr = 32'h0000_4000; i_ok[4] = 2'd2;
    for (int k = 0; k < 300; k++) begin
      drive(); if (bus.mmioOK !== 2'b10 || bus.mmioInData !== def_data(4)) bad++; advance();
    end
    chk("hold_passthru", 64'(bad), 64'd0);
    i_ok[4] = 2'd1; drive();
    chk("hold_then_ok", 64'(bus.mmioOK), 64'd1);
    advance();
    idle_inputs(); drive();
    chk("hold_miss_cnt", 64'(bus.missCount), 64'd2);
    advance();

    // timer tick is a single-cycle exception word
    i_tick = 1'b1; drive(); chk("tick_on", bus.busExc, 64'h0000_0000_0000_C001); advance();
    i_tick = 1'b0; drive(); chk("tick_off", bus.busExc, 64'h0); advance();

    // reset mid-WAIT, request kept active throughout
    i_opm = 5'd1; i_addr = 32'h0000_8000;
    for (int k = 0; k < 50; k++) step();
    i_rst = 1'b1; step(); i_rst = 1'b0;
    drive();
    chk("rst_wait_cnt", 64'(bus.missCount), 64'd0);
    chk("rst_wait_ok", 64'(bus.mmioOK), 64'd0);
    advance();
    for (int k = 0; k < 260; k++) step();
    drop();

    // saturation and clear-with-timeout
    do_reset();
    for (int t = 0; t < MAXC; t++) begin wait_fault(32'h100 + 32'(t), 1'b0, bad); drop(); end
    drive(); chk("sat_full", 64'(bus.missCount), 64'(MAXC)); advance();
    wait_fault(32'h200, 1'b0, bad); drop();
    drive(); chk("sat_hold", 64'(bus.missCount), 64'(MAXC)); advance();
    wait_fault(32'h300, 1'b1, bad);
    drive(); chk("clr_with_tmo", 64'(bus.missCount), 64'd1); advance();
    drop();

    // random run against the model
    for (int seg = 0; seg < 8; seg++) begin
      quiet = (seg % 2) == 1;
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, quiet ? 511 : 15) == 0)
          i_opm = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(1, 31)) : 5'd0;
        if ($urandom_range(0, quiet ? 299 : 63) == 0)
          i_addr = 32'hF000_0000 | 32'($urandom_range(0, 3) << 4);
        for (int d = 0; d < NDEV; d++) begin
          i_ok[d]   = ($urandom_range(0, quiet ? 2047 : 31) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
          i_data[d] = {$urandom, $urandom};
        end
        i_tick = ($urandom_range(0, 7) == 0);
        i_clr  = ($urandom_range(0, quiet ? 1023 : 63) == 0);
        i_rst  = ($urandom_range(0, 999) == 0);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
